// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the processor sequencer and its control-signal decoder.
package proc_sequencer_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE       = 4'd0;
    localparam state_t S_FETCH      = 4'd1;
    localparam state_t S_FETCH_WAIT = 4'd2;
    localparam state_t S_DECODE     = 4'd3;
    localparam state_t S_ULA_OP     = 4'd4;
    localparam state_t S_STORE_RES  = 4'd5;
    localparam state_t S_STORE_REG  = 4'd6;
    localparam state_t S_HALT       = 4'd7;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_NOP  = 4'hE;

endpackage

// File: rtl/proc_sequencer_fetch_timer.sv
// ROM fetch timeout counter. expired is high on the TIMEOUT-th wait cycle,
// so a wait that sees no rom_valid by then is abandoned on that same cycle.
module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Count wait cycles; hold once expired so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Main control FSM: fetch handshake, IR, ULA wait, halt/pause, ROM timeout
// fault and retired-instruction count.
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               resume,
    input  logic               rom_valid,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               ula_done,
    output logic [3:0]         state,
    output logic [3:0]         opcode,
    output logic [INSTR_W-1:0] ir,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    state_t state_q, state_d;
    logic   tmr_clr, tmr_en, tmr_expired;
    logic   ir_load, retire, fault_set, fault_clr;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_fetch_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign opcode = ir[INSTR_W-1 -: 4];
    assign state  = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; run is only looked at on instruction boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (run) state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                // A valid word on the expiry cycle still wins over the timeout.
                if (rom_valid)        state_d = S_DECODE;
                else if (tmr_expired) state_d = S_HALT;
            end
            S_DECODE: begin
                if (opcode == OP_HALT)     state_d = S_HALT;
                else if (opcode == OP_NOP) state_d = run ? S_FETCH : S_IDLE;
                else                       state_d = S_ULA_OP;
            end
            S_ULA_OP:     if (ula_done) state_d = S_STORE_RES;
            S_STORE_RES:  state_d = S_STORE_REG;
            S_STORE_REG:  state_d = run ? S_FETCH : S_IDLE;
            S_HALT:       if (resume) state_d = S_FETCH;
            default:      state_d = S_IDLE;
        endcase
    end

    // Per-state strobes for the timer and datapath registers.
    always_comb begin
        tmr_clr   = (state_q == S_FETCH);
        tmr_en    = (state_q == S_FETCH_WAIT) && !rom_valid;
        ir_load   = (state_q == S_FETCH_WAIT) && rom_valid;
        fault_set = (state_q == S_FETCH_WAIT) && !rom_valid && tmr_expired;
        fault_clr = (state_q == S_HALT) && resume;
        retire    = ((state_q == S_DECODE) && ((opcode == OP_HALT) || (opcode == OP_NOP)))
                  || (state_q == S_STORE_REG);
        halted    = (state_q == S_HALT);
    end

    // IR, sticky fault flag and free-running retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            fault   <= 1'b0;
            retired <= '0;
        end else begin
            if (ir_load)        ir    <= instr_data;
            if (fault_set)      fault <= 1'b1;
            else if (fault_clr) fault <= 1'b0;
            if (retire)         retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench: builds a per-cycle expected trace from instruction-level
// rules (fetch latency, ULA latency, opcode class, run level), drives inputs
// from that trace and compares every cycle.
module tb_proc_sequencer;
    import proc_sequencer_pkg::*;

    localparam int TO = 15;
    localparam int CW = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        run = 1'b0, resume = 1'b0, rom_valid = 1'b0, ula_done = 1'b0;
    logic [15:0] instr_data = '0;
    logic [3:0]  state, opcode;
    logic [15:0] ir;
    logic        halted, fault;
    logic [CW-1:0] retired;

    proc_sequencer #(.INSTR_W(16), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .resume(resume),
        .rom_valid(rom_valid), .instr_data(instr_data), .ula_done(ula_done),
        .state(state), .opcode(opcode), .ir(ir), .halted(halted),
        .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    st;
        logic          rv, ud, rn, rs;
        logic [15:0]   dat;
        logic [15:0]   ir;
        logic          flt;
        logic [CW-1:0] ret;
    } cyc_t;

    cyc_t          q[$];
    logic [15:0]   m_ir;
    logic          m_fault;
    logic [CW-1:0] m_ret;
    int            n_chk = 0, n_fail = 0;
    int            cyc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction

    // One expected cycle: the visible registers are the model values before
    // this cycle's edge takes effect.
    task automatic push(input logic [3:0] st, input logic rv, input logic ud,
                        input logic rn, input logic rs, input logic [15:0] dat);
        cyc_t c;
        c.st = st; c.rv = rv; c.ud = ud; c.rn = rn; c.rs = rs; c.dat = dat;
        c.ir = m_ir; c.flt = m_fault; c.ret = m_ret;
        q.push_back(c);
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++) push(S_IDLE, rb(), rb(), 1'b0, rb(), rw());
        push(S_IDLE, rb(), rb(), 1'b1, rb(), rw());
    endtask

    // Halted for n cycles (run level random, ignored), then a resume pulse.
    task automatic halt_seq(input int n);
        for (int i = 0; i < n; i++) push(S_HALT, rb(), rb(), rb(), 1'b0, rw());
        push(S_HALT, rb(), rb(), rb(), 1'b1, rw());
        m_fault = 1'b0;
    endtask

    // One instruction starting in S_FETCH. rom_lat >= TO means ROM never answers.
    task automatic gen_instr(input logic [15:0] w, input int rom_lat, input int ula_lat,
                             input logic run_after, input int halt_len, output logic to_idle);
        logic [3:0] op;
        to_idle = 1'b0;
        push(S_FETCH, rb(), rb(), rb(), rb(), rw());
        if (rom_lat >= TO) begin
            for (int i = 0; i < TO; i++) push(S_FETCH_WAIT, 1'b0, rb(), rb(), rb(), rw());
            m_fault = 1'b1;
            halt_seq(halt_len);
        end else begin
            for (int i = 0; i < rom_lat; i++) push(S_FETCH_WAIT, 1'b0, rb(), rb(), rb(), rw());
            push(S_FETCH_WAIT, 1'b1, rb(), rb(), rb(), w);
            m_ir = w;
            op = w[15:12];
            if (op == 4'hF) begin
                push(S_DECODE, rb(), rb(), rb(), rb(), rw());
                m_ret = m_ret + 1'b1;
                halt_seq(halt_len);
            end else if (op == 4'hE) begin
                push(S_DECODE, rb(), rb(), run_after, rb(), rw());
                m_ret = m_ret + 1'b1;
                to_idle = !run_after;
            end else begin
                push(S_DECODE, rb(), rb(), rb(), rb(), rw());
                for (int i = 0; i < ula_lat; i++) push(S_ULA_OP, rb(), 1'b0, rb(), rb(), rw());
                push(S_ULA_OP, rb(), 1'b1, rb(), rb(), rw());
                push(S_STORE_RES, rb(), rb(), rb(), rb(), rw());
                push(S_STORE_REG, rb(), rb(), run_after, rb(), rw());
                m_ret = m_ret + 1'b1;
                to_idle = !run_after;
            end
        end
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_t c;
            c = q[i];
            @(negedge clk);
            cyc++;
            chk("state",   32'(state),   32'(c.st));
            chk("ir",      32'(ir),      32'(c.ir));
            chk("opcode",  32'(opcode),  32'(c.ir[15:12]));
            chk("fault",   32'(fault),   32'(c.flt));
            chk("retired", 32'(retired), 32'(c.ret));
            chk("halted",  32'(halted),  32'(c.st == S_HALT));
            run = c.rn; resume = c.rs; rom_valid = c.rv;
            ula_done = c.ud; instr_data = c.dat;
        end
    endtask

    initial begin
        logic        ti;
        logic [15:0] w;
        int          k, rl;

        m_ir = '0; m_fault = 1'b0; m_ret = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_state",   32'(state),   32'(S_IDLE));
        chk("rst_ir",      32'(ir),      32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_fault",   32'(fault),   32'h0);
        chk("rst_halted",  32'(halted),  32'h0);
        rst_n = 1'b1;

        // Directed program.
        gen_idle(0);
        gen_instr(16'h2345, 0, 0, 1'b1, 0, ti);       // minimum-latency ALU op
        gen_instr(16'h3001, 0, 3, 1'b1, 0, ti);       // ULA_OP held 4 cycles
        gen_instr(16'h1111, TO, 0, 1'b1, 2, ti);      // ROM timeout -> fault, resume
        gen_instr(16'h4000, TO - 1, 0, 1'b1, 0, ti);  // valid on last wait cycle
        gen_instr(16'hE000, 0, 0, 1'b1, 0, ti);       // NOP
        gen_instr(16'hF000, 0, 0, 1'b1, 4, ti);       // HALT
        gen_instr(16'h5678, 1, 2, 1'b0, 0, ti);       // pause after completion

        // Randomized program.
        for (int n = 0; n < 40; n++) begin
            if (ti) gen_idle($urandom_range(0, 2));
            k = $urandom_range(0, 9);
            w = rw();
            if (k < 6)      w[15:12] = 4'($urandom_range(0, 13));
            else if (k < 8) w[15:12] = 4'hE;
            else            w[15:12] = 4'hF;
            if ($urandom_range(0, 7) == 0)      rl = TO + $urandom_range(0, 1);
            else if ($urandom_range(0, 5) == 0) rl = TO - 1;
            else                                rl = $urandom_range(0, 3);
            gen_instr(w, rl, $urandom_range(0, 4), rb(), $urandom_range(0, 3), ti);
        end
        if (ti) gen_idle(0);
        gen_instr(16'h6789, 0, 0, 1'b0, 0, ti);
        play(q.size());
        q.delete();

        // Asynchronous reset in the middle of a long ULA op.
        gen_idle(0);
        gen_instr(16'h2345, 0, 8, 1'b1, 0, ti);
        play(6);                      // last checked cycle is the 2nd ULA_OP cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state",   32'(state),   32'(S_IDLE));
        chk("arst_ir",      32'(ir),      32'h0);
        chk("arst_retired", 32'(retired), 32'h0);
        chk("arst_fault",   32'(fault),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0;
        q.delete();
        m_ir = '0; m_fault = 1'b0; m_ret = '0;

        // Short program after reset release.
        gen_idle(1);
        gen_instr(16'hE000, 0, 0, 1'b1, 0, ti);
        gen_instr(16'h7abc, 2, 1, 1'b1, 0, ti);
        gen_instr(16'hF000, 0, 0, 1'b1, 1, ti);
        gen_instr(16'h1234, 0, 0, 1'b0, 0, ti);
        gen_idle(2);
        play(q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
